// File: rtl/bnn_uart_tx.sv
// -----------------------------------------------------------------------------
// bnn_uart_tx
// Buffered 8N1 UART transmitter. Bytes from the BNN controller are queued in a
// small FIFO and serialised LSB first onto uart_tx. A new frame is started only
// while the peer asserts uart_rts (synchronised internally); a frame that has
// started always runs to the end of its stop bit. Back-to-back frames are sent
// with no idle gap between the stop bit and the next start bit.
// -----------------------------------------------------------------------------

// Invariant checker for the transmitter. Purely observational; it has no
// outputs and does not influence the design.
module bnn_uart_tx_chk #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_ready,
    input  logic                          busy,
    input  logic                          uart_tx,
    input  logic                          fsm_idle,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);
    localparam logic [CNT_FW-1:0] CNT_ZERO  = {CNT_FW{1'b0}};

    // The byte count can never exceed the storage available.
    count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= FIFO_FULL);

    // tx_ready is exactly "not full" of the registered count.
    ready_match_a: assert property (@(posedge clk) disable iff (!rst_n)
        tx_ready == (fifo_count != FIFO_FULL));

    // busy tracks the frame state and the queue occupancy.
    busy_match_a: assert property (@(posedge clk) disable iff (!rst_n)
        busy == (!fsm_idle || (fifo_count != CNT_ZERO)));

    // The line idles high whenever no frame is in progress.
    idle_high_a: assert property (@(posedge clk) disable iff (!rst_n)
        fsm_idle |-> uart_tx);

endmodule

module bnn_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          uart_rts,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    localparam logic [CNT_W-1:0]  BAUD_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  BAUD_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  BAUD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_FW-1:0] CNT_ZERO  = {CNT_FW{1'b0}};
    localparam logic [CNT_FW-1:0] CNT_ONE   = {{(CNT_FW-1){1'b0}}, 1'b1};
    localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    baud_r;
    logic [CNT_W-1:0]    baud_nxt_s;
    logic [2:0]          bit_idx_r;
    logic [2:0]          bit_idx_nxt_s;
    logic [7:0]          shift_r;
    logic [7:0]          shift_nxt_s;

    logic                rts_meta_r;
    logic                rts_s;

    logic [7:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_FW-1:0]   count_r;
    logic [CNT_FW-1:0]   count_nxt_s;

    logic                push_s;
    logic                pop_s;
    logic                baud_done_s;
    logic                start_ok_s;
    logic                fsm_idle_s;

    logic                uart_tx_r;
    logic                tx_nxt_s;
    logic                busy_r;
    logic                tx_ready_r;

    // ------------------------------------------------------------------
    // Simple decodes
    // ------------------------------------------------------------------
    assign push_s      = tx_valid && tx_ready_r;
    assign baud_done_s = (baud_r == BAUD_ZERO);
    assign start_ok_s  = (count_r != CNT_ZERO) && rts_s;
    assign fsm_idle_s  = (state_r == ST_IDLE);

    assign uart_tx    = uart_tx_r;
    assign busy       = busy_r;
    assign tx_ready   = tx_ready_r;
    assign fifo_count = count_r;

    // Two-flop synchroniser for the asynchronous peer-ready input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_meta_r <= 1'b0;
            rts_s      <= 1'b0;
        end else begin
            rts_meta_r <= uart_rts;
            rts_s      <= rts_meta_r;
        end
    end

    // Frame sequencing: next state, baud counter, bit index, shift register, pop.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    baud_nxt_s  = BAUD_LOAD;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_nxt_s    = BAUD_LOAD;
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                end else begin
                    baud_nxt_s = baud_r - BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_nxt_s  = BAUD_LOAD;
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r - BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    // Back-to-back: the next start bit follows the stop bit directly.
                    if (start_ok_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = mem_r[rd_ptr_r];
                        baud_nxt_s  = BAUD_LOAD;
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r - BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the cycle after the edge, derived from where the FSM is going.
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_nxt_s[0];
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // FIFO occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM state and serialiser datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // FIFO storage, pointers (wrapping modulo depth) and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= tx_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered outputs, each computed from next-state values so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_r  <= 1'b1;
            busy_r     <= 1'b0;
            tx_ready_r <= 1'b1;
        end else begin
            uart_tx_r  <= tx_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE) || (count_nxt_s != CNT_ZERO);
            tx_ready_r <= (count_nxt_s != FIFO_FULL);
        end
    end

    bnn_uart_tx_chk #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_ready   (tx_ready_r),
        .busy       (busy_r),
        .uart_tx    (uart_tx_r),
        .fsm_idle   (fsm_idle_s),
        .fifo_count (count_r)
    );

endmodule

// File: tb/tb_bnn_uart_tx.sv
// -----------------------------------------------------------------------------
// Testbench for bnn_uart_tx. A reference model keeps the byte queue and an
// expected per-cycle line waveform; every cycle the DUT outputs are compared
// against it, and directed checks cover the timing points of interest.
// -----------------------------------------------------------------------------
module tb_bnn_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_rts;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       wave[$];
    logic       m_rts_m;
    logic       m_rts_s;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_ready;
    int         exp_count;

    bnn_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_rts   (uart_rts),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wave.delete();
        m_rts_m   = 1'b0;
        m_rts_s   = 1'b0;
        exp_tx    = 1'b1;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        exp_count = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs seen at the edge.
    task automatic model_edge();
        logic [7:0] b;
        logic       ready_pre;
        ready_pre = (mq.size() < DEPTH);
        if (wave.size() == 0 && mq.size() != 0 && m_rts_s) begin
            b = mq.pop_front();
            repeat (CPB) wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) wave.push_back(b[i]);
            end
            repeat (CPB) wave.push_back(1'b1);
        end
        if (tx_valid && ready_pre) mq.push_back(tx_data);
        m_rts_s = m_rts_m;
        m_rts_m = uart_rts;
        if (wave.size() != 0) begin
            exp_tx   = wave.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        if (mq.size() != 0) exp_busy = 1'b1;
        exp_ready = (mq.size() < DEPTH);
        exp_count = mq.size();
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        chk("uart_tx",    32'(uart_tx),    32'(exp_tx));
        chk("tx_ready",   32'(tx_ready),   32'(exp_ready));
        chk("busy",       32'(busy),       32'(exp_busy));
        chk("fifo_count", 32'(fifo_count), 32'(exp_count));
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((busy || mq.size() != 0 || wave.size() != 0) && n < bound) begin
            step();
            n++;
        end
        chk("drain_busy",  32'(busy), 32'(0));
        chk("drain_model", 32'(mq.size() + wave.size()), 32'(0));
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] byte_v;
        int         m_edge;

        // Reset with the peer ready
        rst_n    = 1'b0;
        uart_rts = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        model_reset();
        repeat (3) step();
        chk("rst_uart_tx",    32'(uart_tx),    32'(1));
        chk("rst_tx_ready",   32'(tx_ready),   32'(1));
        chk("rst_busy",       32'(busy),       32'(0));
        chk("rst_fifo_count", 32'(fifo_count), 32'(0));
        rst_n = 1'b1;
        repeat (4) step();

        // Single byte 0xA5: start bit at N+1..N+4, busy falls at N+41
        byte_v = 8'hA5;
        push(byte_v);
        for (int k = 1; k <= 41; k++) begin
            step();
            if (k >= 1 && k <= 4)   chk("a5_start", 32'(uart_tx), 32'(0));
            if (k >= 5 && k <= 36)  chk("a5_bit",   32'(uart_tx), 32'(byte_v[(k - 5) / 4]));
            if (k >= 37 && k <= 40) chk("a5_stop",  32'(uart_tx), 32'(1));
            if (k == 40)            chk("a5_busy_hi", 32'(busy),  32'(1));
            if (k == 41)            chk("a5_busy_lo", 32'(busy),  32'(0));
        end
        repeat (3) step();

        // Back-to-back burst filling the FIFO
        for (int i = 1; i <= 5; i++) begin
            tx_data  = 8'(i);
            tx_valid = 1'b1;
            step();
        end
        tx_valid = 1'b0;
        chk("full_tx_ready", 32'(tx_ready),   32'(0));
        chk("full_count",    32'(fifo_count), 32'(4));
        drain(400);

        // Randomised traffic with occasional flow-control changes
        for (int i = 0; i < 500; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) uart_rts = ~uart_rts;
            step();
        end
        tx_valid = 1'b0;
        uart_rts = 1'b1;
        drain(800);

        // Flow control: byte held while peer not ready, start at M+3 after raise
        uart_rts = 1'b0;
        repeat (3) step();
        push(8'h3C);
        repeat (8) step();
        chk("fc_hold_tx",    32'(uart_tx),    32'(1));
        chk("fc_hold_count", 32'(fifo_count), 32'(1));
        uart_rts = 1'b1;
        m_edge   = cyc;
        step();
        step();
        chk("fc_m2_idle",  32'(uart_tx), 32'(1));
        step();
        chk("fc_m3_start", 32'(uart_tx), 32'(0));
        chk("fc_m3_edge",  32'(cyc - m_edge), 32'(3));
        drain(200);

        // RTS drop during data bit 3: frame completes, next byte waits
        push(8'hAA);
        push(8'h55);
        repeat (16) step();
        uart_rts = 1'b0;
        repeat (45) step();
        chk("rtsdrop_tx",    32'(uart_tx),    32'(1));
        chk("rtsdrop_count", 32'(fifo_count), 32'(1));
        chk("rtsdrop_busy",  32'(busy),       32'(1));
        uart_rts = 1'b1;
        drain(200);

        // Reset mid-frame with two bytes queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_uart_tx",  32'(uart_tx),    32'(1));
        chk("mrst_count",    32'(fifo_count), 32'(0));
        chk("mrst_tx_ready", 32'(tx_ready),   32'(1));
        chk("mrst_busy",     32'(busy),       32'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (60) step();
        chk("post_rst_tx",   32'(uart_tx), 32'(1));
        chk("post_rst_busy", 32'(busy),    32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
